// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the pipelined MIPS core: captures decoded operands/control,
// resolves EX/MEM and MEM/WB operand forwarding, and flags load-use hazards back to ID.
module id_ex_stage #(
   parameter int DW = 32,
   parameter int RW = 5
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          id_valid,
   input  logic [DW-1:0] id_pc,
   input  logic [DW-1:0] id_rd1,
   input  logic [DW-1:0] id_rd2,
   input  logic [DW-1:0] id_imm,
   input  logic [RW-1:0] id_rs,
   input  logic [RW-1:0] id_rt,
   input  logic [RW-1:0] id_rd_dst,
   input  logic [4:0]    id_alu_op,
   input  logic          id_alusrc,
   input  logic          id_regwrite,
   input  logic          id_memread,
   input  logic          id_memwrite,
   input  logic [1:0]    id_wdsel,
   input  logic          stall,
   input  logic          flush,
   input  logic          exmem_regwrite,
   input  logic [RW-1:0] exmem_rd,
   input  logic [DW-1:0] exmem_result,
   input  logic          memwb_regwrite,
   input  logic [RW-1:0] memwb_rd,
   input  logic [DW-1:0] memwb_wdata,
   output logic          ex_valid,
   output logic [DW-1:0] ex_A,
   output logic [DW-1:0] ex_B,
   output logic [4:0]    ex_alu_op,
   output logic [DW-1:0] ex_store_data,
   output logic [DW-1:0] ex_pc,
   output logic [RW-1:0] ex_rd_dst,
   output logic          ex_regwrite,
   output logic          ex_memread,
   output logic          ex_memwrite,
   output logic [1:0]    ex_wdsel,
   output logic          load_use_hazard
);

   logic          r_valid;
   logic [DW-1:0] r_pc;
   logic [DW-1:0] r_rd1;
   logic [DW-1:0] r_rd2;
   logic [DW-1:0] r_imm;
   logic [RW-1:0] r_rs;
   logic [RW-1:0] r_rt;
   logic [RW-1:0] r_rd_dst;
   logic [4:0]    r_alu_op;
   logic          r_alusrc;
   logic          r_regwrite;
   logic          r_memread;
   logic          r_memwrite;
   logic [1:0]    r_wdsel;

   logic [DW-1:0] w_fwd_a;
   logic [DW-1:0] w_fwd_b;

   // NOTE: the default assignment first guarantees every path drives the output, so no latch is inferred.
   always_comb begin
      w_fwd_a = r_rd1;
      if (exmem_regwrite && (exmem_rd != '0) && (exmem_rd == r_rs))
         w_fwd_a = exmem_result;
      else if (memwb_regwrite && (memwb_rd != '0) && (memwb_rd == r_rs))
         w_fwd_a = memwb_wdata;
   end

   always_comb begin
      w_fwd_b = r_rd2;
      if (exmem_regwrite && (exmem_rd != '0) && (exmem_rd == r_rt))
         w_fwd_b = exmem_result;
      else if (memwb_regwrite && (memwb_rd != '0) && (memwb_rd == r_rt))
         w_fwd_b = memwb_wdata;
   end

   // NOTE: non-blocking assignments keep every register sampling pre-edge values, matching real flops.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_valid    <= 1'b0;
         r_pc       <= '0;
         r_rd1      <= '0;
         r_rd2      <= '0;
         r_imm      <= '0;
         r_rs       <= '0;
         r_rt       <= '0;
         r_rd_dst   <= '0;
         r_alu_op   <= '0;
         r_alusrc   <= 1'b0;
         r_regwrite <= 1'b0;
         r_memread  <= 1'b0;
         r_memwrite <= 1'b0;
         r_wdsel    <= '0;
      end else if (flush) begin
         r_valid    <= 1'b0;
         r_alu_op   <= '0;
         r_alusrc   <= 1'b0;
         r_regwrite <= 1'b0;
         r_memread  <= 1'b0;
         r_memwrite <= 1'b0;
         r_wdsel    <= '0;
      end else if (stall) begin
         // Re-capture forwarded operands so a producer retiring mid-stall is not lost.
         r_rd1 <= w_fwd_a;
         r_rd2 <= w_fwd_b;
      end else begin
         r_pc       <= id_pc;
         r_rd1      <= id_rd1;
         r_rd2      <= id_rd2;
         r_imm      <= id_imm;
         r_rs       <= id_rs;
         r_rt       <= id_rt;
         r_rd_dst   <= id_rd_dst;
         r_valid    <= id_valid;
         r_alu_op   <= id_valid ? id_alu_op   : 5'b0;
         r_alusrc   <= id_valid ? id_alusrc   : 1'b0;
         r_regwrite <= id_valid ? id_regwrite : 1'b0;
         r_memread  <= id_valid ? id_memread  : 1'b0;
         r_memwrite <= id_valid ? id_memwrite : 1'b0;
         r_wdsel    <= id_valid ? id_wdsel    : 2'b0;
      end
   end

   assign ex_valid        = r_valid;
   assign ex_A            = w_fwd_a;
   assign ex_B            = r_alusrc ? r_imm : w_fwd_b;
   assign ex_alu_op       = r_alu_op;
   assign ex_store_data   = w_fwd_b;
   assign ex_pc           = r_pc;
   assign ex_rd_dst       = r_rd_dst;
   assign ex_regwrite     = r_valid & r_regwrite;
   assign ex_memread      = r_valid & r_memread;
   assign ex_memwrite     = r_valid & r_memwrite;
   assign ex_wdsel        = r_wdsel;
   assign load_use_hazard = r_valid && r_memread && (r_rd_dst != '0) &&
                            ((r_rd_dst == id_rs) || (r_rd_dst == id_rt));

endmodule
